// File: rtl/mul_issue_sched.sv
// mul_issue_sched: issue scheduler for the fixed-latency multiply pipeline.
// Keeps a shadow of in-flight multiplies (valid, writes, destination) that
// advances in lock-step with EX1..EX<MUL_LAT>. Decode is stalled on RAW,
// WAW and writeback-port conflicts, and while a fence waits for the
// multiplier to drain. It also drives the writeback mux select.
// Optional build macro: MUL_BYPASS_EN. When it is defined, an operand whose
// only producer is in the last stage is forwarded instead of stalled, and
// the fwd_rs1_o/fwd_rs2_o outputs exist.
module mul_issue_sched #(
  parameter int unsigned MUL_LAT    = 5,
  parameter int unsigned ALU_WB_LAT = 1,
  parameter int unsigned REG_ID_W   = 5,
  parameter int unsigned CNT_W      = 32
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                issue_valid_i,
  input  logic                issue_is_mul_i,
  input  logic                issue_wr_en_i,
  input  logic [REG_ID_W-1:0] issue_wr_reg_i,
  input  logic                issue_rs1_used_i,
  input  logic [REG_ID_W-1:0] issue_rs1_i,
  input  logic                issue_rs2_used_i,
  input  logic [REG_ID_W-1:0] issue_rs2_i,
  input  logic                fence_i,
  output logic                issue_stall_o,
  output logic                issue_fire_o,
  output logic                ex1_valid_o,
  output logic [1:0]          stall_cause_o,
  output logic                wb_sel_mul_o,
  output logic                mul_busy_o,
  output logic [CNT_W-1:0]    stall_cnt_o
`ifdef MUL_BYPASS_EN
  ,
  output logic                fwd_rs1_o,
  output logic                fwd_rs2_o
`endif
);

  // Slot whose multiply retires in the same cycle as an ALU op issued now.
  localparam int unsigned WB_SLOT = MUL_LAT - 1 - ALU_WB_LAT;
  localparam int unsigned LAST    = MUL_LAT - 1;

  localparam logic [1:0] CAUSE_NONE = 2'd0;
  localparam logic [1:0] CAUSE_RAW  = 2'd1;
  localparam logic [1:0] CAUSE_WAW  = 2'd2;
  localparam logic [1:0] CAUSE_WB   = 2'd3;

  logic [MUL_LAT-1:0]  r_v;
  logic [MUL_LAT-1:0]  r_wr;
  logic [REG_ID_W-1:0] r_reg [MUL_LAT];
  logic [CNT_W-1:0]    r_cnt;

  logic [MUL_LAT-1:0] w_m_rs1;
  logic [MUL_LAT-1:0] w_m_rs2;
  logic [MUL_LAT-1:0] w_m_wr;
  logic               w_raw1;
  logic               w_raw2;
  logic               w_alu_wr;
  logic               w_waw;
  logic               w_wbc;
  logic               w_busy;
  logic               w_fence;
  logic [1:0]         w_cause;
  logic               w_stall;
  logic               w_fire;
  logic               w_ex1;

  // Per-slot match of each register under test against writing in-flight muls.
  always_comb begin
    w_m_rs1 = '0;
    w_m_rs2 = '0;
    w_m_wr  = '0;
    for (int unsigned k = 0; k < MUL_LAT; k++) begin
      w_m_rs1[k] = r_v[k] & r_wr[k] & (r_reg[k] == issue_rs1_i);
      w_m_rs2[k] = r_v[k] & r_wr[k] & (r_reg[k] == issue_rs2_i);
      w_m_wr[k]  = r_v[k] & r_wr[k] & (r_reg[k] == issue_wr_reg_i);
    end
  end

`ifdef MUL_BYPASS_EN
  // Last-stage-only producers are forwarded; any younger producer still stalls.
  always_comb begin
    w_raw1    = issue_rs1_used_i & (|w_m_rs1[MUL_LAT-2:0]);
    w_raw2    = issue_rs2_used_i & (|w_m_rs2[MUL_LAT-2:0]);
    fwd_rs1_o = issue_rs1_used_i & w_m_rs1[LAST] & ~(|w_m_rs1[MUL_LAT-2:0]);
    fwd_rs2_o = issue_rs2_used_i & w_m_rs2[LAST] & ~(|w_m_rs2[MUL_LAT-2:0]);
  end
`else
  // Without bypass a producer in any stage stalls the consumer.
  always_comb begin
    w_raw1 = issue_rs1_used_i & (|w_m_rs1);
    w_raw2 = issue_rs2_used_i & (|w_m_rs2);
  end
`endif

  // Hazard classification with RAW > WAW > WB-port/fence priority.
  always_comb begin
    w_alu_wr = ~issue_is_mul_i & issue_wr_en_i;
    w_waw    = w_alu_wr & (|w_m_wr);
    w_wbc    = w_alu_wr & r_v[WB_SLOT] & r_wr[WB_SLOT];
    w_busy   = |r_v;
    w_fence  = fence_i & w_busy;
    w_cause  = CAUSE_NONE;
    if (issue_valid_i) begin
      if (w_raw1 | w_raw2)       w_cause = CAUSE_RAW;
      else if (w_waw)            w_cause = CAUSE_WAW;
      else if (w_wbc | w_fence)  w_cause = CAUSE_WB;
    end
    w_stall = issue_valid_i & (w_cause != CAUSE_NONE);
    w_fire  = issue_valid_i & ~w_stall & ~rst_i;
    w_ex1   = w_fire & issue_is_mul_i;
  end

  // Shadow shift register: advances every cycle, slot 0 takes the new issue.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_v  <= '0;
      r_wr <= '0;
      for (int unsigned k = 0; k < MUL_LAT; k++) begin
        r_reg[k] <= '0;
      end
    end else begin
      r_v      <= {r_v[MUL_LAT-2:0], w_ex1};
      r_wr     <= {r_wr[MUL_LAT-2:0], issue_wr_en_i};
      r_reg[0] <= issue_wr_reg_i;
      for (int unsigned k = 1; k < MUL_LAT; k++) begin
        r_reg[k] <= r_reg[k-1];
      end
    end
  end

  // Saturating count of cycles in which decode was held.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_cnt <= '0;
    end else if (w_stall && (r_cnt != '1)) begin
      r_cnt <= r_cnt + CNT_W'(1);
    end
  end

  // Output drive.
  always_comb begin
    issue_stall_o = w_stall;
    issue_fire_o  = w_fire;
    ex1_valid_o   = w_ex1;
    stall_cause_o = w_cause;
    wb_sel_mul_o  = r_v[LAST] & r_wr[LAST];
    mul_busy_o    = w_busy;
    stall_cnt_o   = r_cnt;
  end

endmodule

// File: doc/mul_issue_sched.md
Name: mul_issue_sched

Overview:
- Issue scheduler for the fixed-latency, fully pipelined multiply unit (EX1..EX5, one result per cycle, no internal stalls).
- Sits between decode and the EX1 pipeline register.
- Keeps a shadow shift register of in-flight multiplies (valid, destination register).
- Stalls decode on RAW, WAW and writeback-port conflicts, and drives the writeback mux select between the ALU result and the multiply result.

Parameters:
MUL_LAT, 5, multiply pipeline depth; a mul issued in cycle t writes back in cycle t+MUL_LAT
ALU_WB_LAT, 1, cycles from issue to writeback for non-mul register writers; legal range 1..MUL_LAT-1
REG_ID_W, 5, register identifier width (matches reg_id_t)
CNT_W, 32, stall counter width

Ports:
clk_i  in  1  clock
rst_i  in  1  synchronous active-high reset
issue_valid_i  in  1  decode holds an instruction
issue_is_mul_i  in  1  instruction is a multiply
issue_wr_en_i  in  1  instruction writes a register
issue_wr_reg_i  in  REG_ID_W  destination register
issue_rs1_used_i  in  1  rs1 is read
issue_rs1_i  in  REG_ID_W  source register 1
issue_rs2_used_i  in  1  rs2 is read
issue_rs2_i  in  REG_ID_W  source register 2
fence_i  in  1  block issue until no multiply is in flight
issue_stall_o  out  1  decode must hold (combinational)
issue_fire_o  out  1  issue_valid_i & ~issue_stall_o
ex1_valid_o  out  1  EX1 valid to the mul pipeline (issue_fire_o & issue_is_mul_i)
stall_cause_o  out  2  0 none, 1 RAW, 2 WAW, 3 WB port/fence
wb_sel_mul_o  out  1  writeback port takes the multiply result this cycle
mul_busy_o  out  1  any shadow slot valid
stall_cnt_o  out  CNT_W  cycles with issue_valid_i & issue_stall_o

Behaviour:
- Shadow slots slot[0..MUL_LAT-1] each hold (v, wr, reg). slot[k] mirrors EX(k+1).
- Slots shift every cycle unconditionally. slot[0] loads (issue_fire_o & issue_is_mul_i, issue_wr_en_i, issue_wr_reg_i). slot[MUL_LAT-1] drops out.
- Match on slot k means slot[k].v & slot[k].wr & slot[k].reg == the register under test.
- RAW: issue_rs1_used_i & match on rs1, or the same for rs2, in any slot -> stall.
- WAW: non-mul with issue_wr_en_i and a match on issue_wr_reg_i in any slot -> stall. A mul-after-mul to the same destination is not stalled, because fixed latency keeps the writes ordered.
- WB port conflict: non-mul with issue_wr_en_i while slot[MUL_LAT-1-ALU_WB_LAT] has v & wr -> stall.
- Fence: fence_i & mul_busy_o -> stall with cause 3.
- Cause priority is RAW > WAW > WB/fence. stall_cause_o is 0 when issue_valid_i=0 or there is no stall. issue_stall_o = issue_valid_i & (any cause).
- wb_sel_mul_o = slot[MUL_LAT-1].v & slot[MUL_LAT-1].wr. This is registered-slot based, so it is glitch-free within the cycle.
- stall_cnt_o increments by 1 per stalled cycle and saturates at all-ones.
- Reset: all slots invalidated; stall_cnt_o=0; every output 0 in the cycle after reset. Reset asserted mid-operation discards in-flight shadow entries. The datapath is reset by the same rst_i, so nothing is orphaned.
- While rst_i is high, issue_fire_o=0.
- Simultaneous events: an instruction whose own destination is dropping out of slot[MUL_LAT-1] this cycle still counts as a match in that slot. Without bypass, the register file write is not visible until the next cycle.

Optional Feature:
- Macro: MUL_BYPASS_EN.
- When defined:
  - A RAW match found only in slot[MUL_LAT-1] does not stall.
  - Adds outputs fwd_rs1_o and fwd_rs2_o (1 bit each). Each asserts when the corresponding used source matches slot[MUL_LAT-1] and no younger slot matches; the operand is then taken from result_o.
  - A match in any younger slot still stalls, so the youngest producer always wins.
- When undefined:
  - Any slot match stalls.
  - fwd ports do not exist.

Test Plan:
- Reset, then issue mul x3 := x1*x2 at cycle 0 -> ex1_valid_o=1 in cycle 0; wb_sel_mul_o=1 in cycle 5 only; mul_busy_o=1 in cycles 1..5, 0 in cycle 6.
- Mul writing x3 at cycle 0, then ALU add x4 := x3+x1 held valid from cycle 1 -> without bypass, stalls cycles 1..5 with stall_cause_o=1 and fires cycle 6, stall_cnt_o=5. With MUL_BYPASS_EN, fires cycle 5 with fwd_rs1_o=1, stall_cnt_o=4.
- Mul writing x7 at cycle 0, ALU write x7 with no x7 source at cycle 2 -> stall_cause_o=2 through cycle 5, fires cycle 6.
- Mul writing x5 at cycle 0, independent ALU write x9 at cycle 4 (ALU_WB_LAT=1) -> stall_cause_o=3 in cycle 4, fires cycle 5. The same ALU write at cycle 3 fires immediately.
- Back-to-back muls x1..x5 on cycles 0..4 plus fence_i with an ALU op at cycle 5 -> stalls cycles 5..9 (cause 3), fires cycle 10; wb_sel_mul_o high in cycles 5..9.
- Assert rst_i in cycle 2 with 2 muls in flight -> mul_busy_o=0, wb_sel_mul_o=0 and stall_cnt_o=0 from cycle 3 onward. A dependent instruction presented in cycle 3 fires without stall.
